dcache_wb_buffer: RTL and testbench

- Parametrised write-back victim buffer between the data-cache pipeline and the memory write port.
- Accepts dirty lines evicted by the cache and drains them to memory one burst per line.
- While a line is queued, cache lookups can read it (read hit) and merge stores into it (write hit).
- Successor to the fixed single-line-width dirty FIFO: depth, line width and address width are configurable; adds duplicate-address coalescing and a defined drain-lock rule.

---
 rtl/dcache_pkg.sv | 22 ++
 rtl/dcache_wb_entry.sv | 64 ++++++
 rtl/dcache_wb_buffer.sv | 173 +++++++++++++++++
 tb/tb_dcache_wb_buffer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared definitions for the data-cache write-back victim buffer.
package dcache_pkg;

   localparam int unsigned WORD_W = 32;

   // Drain FSM encoding
   localparam logic [0:0] StIdle = 1'b0;
   localparam logic [0:0] StSend = 1'b1;

   // Byte-granular merge of a store into an existing word
   function automatic logic [WORD_W-1:0] merge_word(input logic [WORD_W-1:0] old_w,
                                                    input logic [WORD_W-1:0] new_w,
                                                    input logic [3:0]        wsel);
      logic [WORD_W-1:0] res;
      res = old_w;
      for (int b = 0; b < 4; b++) begin
         if (wsel[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/dcache_wb_entry.sv
// One victim-buffer slot: valid bit, line tag and line data.
// A write (allocate or in-place overwrite) and a word merge may hit in the same
// cycle; the write lands first and the merge is applied on top of it.
module dcache_wb_entry
   import dcache_pkg::*;
#(
   parameter int unsigned TAG_W  = 28,
   parameter int unsigned LINE_W = 128,
   parameter int unsigned WIDX_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en_i,
   input  logic [TAG_W-1:0]  wr_tag_i,
   input  logic [LINE_W-1:0] wr_data_i,
   input  logic              mrg_en_i,
   input  logic [WIDX_W-1:0] mrg_widx_i,
   input  logic [3:0]        mrg_wsel_i,
   input  logic [WORD_W-1:0] mrg_wdata_i,
   input  logic              clr_i,
   output logic              valid_o,
   output logic [TAG_W-1:0]  tag_o,
   output logic [LINE_W-1:0] data_o
);

   logic              valid_q, valid_d;
   logic [TAG_W-1:0]  tag_q, tag_d;
   logic [LINE_W-1:0] data_q, data_d;

   // Next-state: pop clears, write sets, merge overlays the selected word
   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      data_d  = data_q;
      if (clr_i) valid_d = 1'b0;
      if (wr_en_i) begin
         valid_d = 1'b1;
         tag_d   = wr_tag_i;
         data_d  = wr_data_i;
      end
      if (mrg_en_i) begin
         data_d[mrg_widx_i*WORD_W +: WORD_W] =
            merge_word(data_d[mrg_widx_i*WORD_W +: WORD_W], mrg_wdata_i, mrg_wsel_i);
      end
   end

   // Slot state register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         tag_q   <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         tag_q   <= tag_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign tag_o   = tag_q;
   assign data_o  = data_q;

endmodule

// File: rtl/dcache_wb_buffer.sv
// Write-back victim buffer: queues evicted dirty lines, serves lookups and store
// merges against them, and drains the oldest line to memory one burst at a time.
module dcache_wb_buffer
   import dcache_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned LINE_W = 128
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic [ADDR_W-1:0]          push_addr_i,
   input  logic [LINE_W-1:0]          push_data_i,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o,
   input  logic [ADDR_W-1:0]          lk_addr_i,
   output logic                       lk_hit_o,
   output logic [WORD_W-1:0]          lk_rdata_o,
   input  logic                       lk_wen_i,
   input  logic [3:0]                 lk_wsel_i,
   input  logic [WORD_W-1:0]          lk_wdata_i,
   output logic                       lk_stall_o,
   output logic                       wr_req_o,
   output logic [ADDR_W-1:0]          wr_addr_o,
   output logic [LINE_W-1:0]          wr_data_o,
   output logic [7:0]                 wr_len_o,
   input  logic                       wr_rdy_i
);

   localparam int unsigned WORDS  = LINE_W / WORD_W;
   localparam int unsigned OFF_W  = $clog2(LINE_W / 8);
   localparam int unsigned WIDX_W = (OFF_W > 2) ? OFF_W - 2 : 1;
   localparam int unsigned TAG_W  = ADDR_W - OFF_W;
   localparam int unsigned IDX_W  = $clog2(DEPTH);
   localparam int unsigned PTR_W  = IDX_W + 1;

   logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   logic [0:0]        state_q, state_d;

   logic              ent_valid [DEPTH];
   logic [TAG_W-1:0]  ent_tag   [DEPTH];
   logic [LINE_W-1:0] ent_data  [DEPTH];
   logic [DEPTH-1:0]  ent_wr, ent_mrg, ent_clr, locked;

   logic [IDX_W-1:0]  head_idx, tail_idx, scan_idx, lk_idx, push_idx;
   logic [TAG_W-1:0]  lk_tag, push_tag;
   logic [WIDX_W-1:0] lk_widx;
   logic              lk_locked, mrg_ok, push_match, push_ok, alloc, pop;

   logic unused_addr_bits;
   assign unused_addr_bits = ^{push_addr_i[OFF_W-1:0], lk_addr_i[1:0]};

   assign head_idx = rptr_q[IDX_W-1:0];
   assign tail_idx = wptr_q[IDX_W-1:0];
   assign empty_o  = (wptr_q == rptr_q);
   assign full_o   = (wptr_q[IDX_W-1:0] == rptr_q[IDX_W-1:0]) &&
                     (wptr_q[IDX_W] != rptr_q[IDX_W]);
   assign count_o  = wptr_q - rptr_q;

   assign lk_tag   = lk_addr_i[ADDR_W-1:OFF_W];
   assign lk_widx  = lk_addr_i[OFF_W-1:2];
   assign push_tag = push_addr_i[ADDR_W-1:OFF_W];

   // The head entry is locked for the whole time its burst is outstanding
   always_comb begin
      locked = '0;
      for (int i = 0; i < DEPTH; i++) begin
         locked[i] = (state_q == StSend) && (head_idx == IDX_W'(i));
      end
   end

   // Lookup: scan oldest to youngest so the last match is the youngest copy
   always_comb begin
      lk_hit_o = 1'b0;
      lk_idx   = '0;
      scan_idx = '0;
      for (int k = 0; k < DEPTH; k++) begin
         scan_idx = head_idx + IDX_W'(k);
         if (ent_valid[scan_idx] && (ent_tag[scan_idx] == lk_tag)) begin
            lk_hit_o = 1'b1;
            lk_idx   = scan_idx;
         end
      end
   end

   assign lk_rdata_o = ent_data[lk_idx][lk_widx*WORD_W +: WORD_W];
   assign lk_locked  = locked[lk_idx];
   assign lk_stall_o = lk_wen_i && lk_hit_o && lk_locked;
   assign mrg_ok     = lk_wen_i && lk_hit_o && !lk_locked;

   // Push coalescing: at most one valid unlocked copy of a line ever exists
   always_comb begin
      push_match = 1'b0;
      push_idx   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_valid[i] && !locked[i] && (ent_tag[i] == push_tag)) begin
            push_match = 1'b1;
            push_idx   = IDX_W'(i);
         end
      end
   end

   assign push_ok = push_i && !full_o;
   assign alloc   = push_ok && !push_match;
   assign pop     = (state_q == StSend) && wr_rdy_i;

   // Per-entry write, merge and pop strobes
   always_comb begin
      ent_wr  = '0;
      ent_mrg = '0;
      ent_clr = '0;
      for (int i = 0; i < DEPTH; i++) begin
         ent_wr[i]  = push_ok && ((push_match ? push_idx : tail_idx) == IDX_W'(i));
         ent_mrg[i] = mrg_ok && (lk_idx == IDX_W'(i));
         ent_clr[i] = pop && (head_idx == IDX_W'(i));
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : gen_entry
      dcache_wb_entry #(
         .TAG_W  (TAG_W),
         .LINE_W (LINE_W),
         .WIDX_W (WIDX_W)
      ) u_entry (
         .clk         (clk),
         .rst         (rst),
         .wr_en_i     (ent_wr[g]),
         .wr_tag_i    (push_tag),
         .wr_data_i   (push_data_i),
         .mrg_en_i    (ent_mrg[g]),
         .mrg_widx_i  (lk_widx),
         .mrg_wsel_i  (lk_wsel_i),
         .mrg_wdata_i (lk_wdata_i),
         .clr_i       (ent_clr[g]),
         .valid_o     (ent_valid[g]),
         .tag_o       (ent_tag[g]),
         .data_o      (ent_data[g])
      );
   end

   // Pointer advance and drain FSM next-state
   always_comb begin
      wptr_d  = wptr_q + PTR_W'(alloc);
      rptr_d  = rptr_q + PTR_W'(pop);
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (!empty_o) state_d = StSend;
         StSend:  if (wr_rdy_i) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Pointer and FSM registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         state_q <= StIdle;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         state_q <= state_d;
      end
   end

   assign wr_req_o  = (state_q == StSend);
   assign wr_addr_o = {ent_tag[head_idx], {OFF_W{1'b0}}};
   assign wr_data_o = ent_data[head_idx];
   assign wr_len_o  = 8'(WORDS - 1);

endmodule

// File: tb/tb_dcache_wb_buffer.sv
// Self-checking bench for dcache_wb_buffer: scoreboard of expected drains,
// plus direct checks of lookup, merge, lock, full/wrap, coalesce and reset.
module tb_dcache_wb_buffer;

   logic         clk = 1'b0;
   logic         rst;
   logic         push_i;
   logic [31:0]  push_addr_i;
   logic [127:0] push_data_i;
   logic         full_o, empty_o;
   logic [2:0]   count_o;
   logic [31:0]  lk_addr_i;
   logic         lk_hit_o;
   logic [31:0]  lk_rdata_o;
   logic         lk_wen_i;
   logic [3:0]   lk_wsel_i;
   logic [31:0]  lk_wdata_i;
   logic         lk_stall_o;
   logic         wr_req_o;
   logic [31:0]  wr_addr_o;
   logic [127:0] wr_data_o;
   logic [7:0]   wr_len_o;
   logic         wr_rdy_i;

   typedef struct {
      logic [31:0]  addr;
      logic [127:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   localparam logic [31:0]  A1 = 32'h2468_7570;
   localparam logic [31:0]  A2 = 32'h1168_7570;
   localparam logic [127:0] D1 = 128'h12345678_91023456_78910234_11111111;
   localparam logic [127:0] D2 = 128'hAAAA0003_BBBB0002_CCCC0001_DDDD0000;

   dcache_wb_buffer #(
      .DEPTH  (4),
      .ADDR_W (32),
      .LINE_W (128)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push_i),
      .push_addr_i (push_addr_i),
      .push_data_i (push_data_i),
      .full_o      (full_o),
      .empty_o     (empty_o),
      .count_o     (count_o),
      .lk_addr_i   (lk_addr_i),
      .lk_hit_o    (lk_hit_o),
      .lk_rdata_o  (lk_rdata_o),
      .lk_wen_i    (lk_wen_i),
      .lk_wsel_i   (lk_wsel_i),
      .lk_wdata_i  (lk_wdata_i),
      .lk_stall_o  (lk_stall_o),
      .wr_req_o    (wr_req_o),
      .wr_addr_o   (wr_addr_o),
      .wr_data_o   (wr_data_o),
      .wr_len_o    (wr_len_o),
      .wr_rdy_i    (wr_rdy_i)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // mode 0: new slot, 1: coalesce into youngest queued copy, 2: dropped
   task automatic do_push(input logic [31:0] a, input logic [127:0] d, input int mode);
      exp_t e;
      bit   done;
      push_i      = 1'b1;
      push_addr_i = a;
      push_data_i = d;
      tick();
      push_i = 1'b0;
      e.addr = {a[31:4], 4'h0};
      e.data = d;
      if (mode == 0) begin
         sb.push_back(e);
      end else if (mode == 1) begin
         done = 1'b0;
         for (int i = sb.size() - 1; i >= 0; i--) begin
            if (!done && sb[i].addr == e.addr) begin
               sb[i].data = d;
               done = 1'b1;
            end
         end
      end
   endtask

   // Reference byte merge into the youngest queued copy of the line
   task automatic model_store(input logic [31:0] a, input logic [3:0] wsel, input logic [31:0] wd);
      bit done;
      int widx;
      done = 1'b0;
      widx = int'(a[3:2]);
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (!done && sb[i].addr == {a[31:4], 4'h0}) begin
            for (int b = 0; b < 4; b++) begin
               if (wsel[b]) sb[i].data[widx*32 + b*8 +: 8] = wd[b*8 +: 8];
            end
            done = 1'b1;
         end
      end
   endtask

   task automatic wait_empty(input int budget);
      int n;
      n = 0;
      while (!empty_o && n < budget) begin
         tick();
         n++;
      end
      if (!empty_o) check_eq("drain_timeout", 1'b0, 1'b1);
   endtask

   // Scoreboard: a burst transfers at the next posedge when req and rdy are both high
   always @(negedge clk) begin
      exp_t e;
      if (!rst && wr_req_o && wr_rdy_i) begin
         if (sb.size() == 0) begin
            check_eq("drain_unexpected", 1'b1, 1'b0);
         end else begin
            e = sb.pop_front();
            check_eq("drain_addr", wr_addr_o, e.addr);
            check_eq("drain_data", wr_data_o, e.data);
            check_eq("drain_len", wr_len_o, 8'd3);
         end
      end
   end

   initial begin
      logic [127:0] held;
      rst = 1'b1; push_i = 1'b0; push_addr_i = '0; push_data_i = '0;
      lk_addr_i = '0; lk_wen_i = 1'b0; lk_wsel_i = '0; lk_wdata_i = '0; wr_rdy_i = 1'b0;
      tick(); tick();
      rst = 1'b0;

      // Reset state
      check_eq("rst_req", wr_req_o, 1'b0);
      check_eq("rst_full", full_o, 1'b0);
      check_eq("rst_empty", empty_o, 1'b1);
      check_eq("rst_count", count_o, 3'd0);
      check_eq("rst_hit", lk_hit_o, 1'b0);
      check_eq("rst_stall", lk_stall_o, 1'b0);
      check_eq("rst_waddr", wr_addr_o, 32'h0);
      check_eq("rst_wdata", wr_data_o, 128'h0);

      // Single drain
      do_push(A1, D1, 0);
      check_eq("sd_req_early", wr_req_o, 1'b0);
      check_eq("sd_count", count_o, 3'd1);
      tick();
      check_eq("sd_req", wr_req_o, 1'b1);
      check_eq("sd_addr", wr_addr_o, A1);
      check_eq("sd_len", wr_len_o, 8'd3);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("sd_hold_req", wr_req_o, 1'b1);
         check_eq("sd_hold_data", wr_data_o, D1);
      end
      wr_rdy_i = 1'b1;
      tick();
      wr_rdy_i = 1'b0;
      check_eq("sd_empty", empty_o, 1'b1);
      check_eq("sd_req_low", wr_req_o, 1'b0);

      // Read hit on the second of two queued lines
      do_push(A1, D1, 0);
      do_push(A2, D2, 0);
      lk_addr_i = 32'h1168_7574;
      #1;
      check_eq("rh_hit", lk_hit_o, 1'b1);
      check_eq("rh_rdata", lk_rdata_o, 32'hCCCC_0001);
      check_eq("rh_count", count_o, 3'd2);

      // Write hit on the unlocked entry
      lk_addr_i = A2; lk_wen_i = 1'b1; lk_wsel_i = 4'b0011; lk_wdata_i = 32'h3333_3333;
      #1;
      check_eq("wh_stall", lk_stall_o, 1'b0);
      tick();
      lk_wen_i = 1'b0;
      model_store(A2, 4'b0011, 32'h3333_3333);
      check_eq("wh_rdata", lk_rdata_o, 32'hDDDD_3333);

      // Store to the locked head is stalled and not applied
      check_eq("dl_req", wr_req_o, 1'b1);
      lk_addr_i = A1; lk_wen_i = 1'b1; lk_wsel_i = 4'b1111; lk_wdata_i = 32'hDEAD_BEEF;
      #1;
      check_eq("dl_hit", lk_hit_o, 1'b1);
      check_eq("dl_stall", lk_stall_o, 1'b1);
      tick();
      lk_wen_i = 1'b0;
      check_eq("dl_data_kept", wr_data_o, D1);
      wr_rdy_i = 1'b1;
      tick();
      check_eq("dl_miss_after_pop", lk_hit_o, 1'b0);
      wait_empty(20);
      wr_rdy_i = 1'b0;

      // Full and pointer wrap, two rounds
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 4; i++) begin
            do_push(32'h1000_0000 + 32'(r*256 + i*16), {$urandom, $urandom, $urandom, $urandom}, 0);
         end
         check_eq("fw_full", full_o, 1'b1);
         check_eq("fw_count", count_o, 3'd4);
         do_push(32'h2000_0000, {4{$urandom}}, 2);
         check_eq("fw_drop_count", count_o, 3'd4);
         wr_rdy_i = 1'b1;
         wait_empty(40);
         wr_rdy_i = 1'b0;
         check_eq("fw_empty", empty_o, 1'b1);
      end

      // Coalesce into an unlocked entry, then reset mid-drain
      do_push(32'h3000_0040, 128'hA5A5, 0);
      do_push(32'h3000_0044, 128'h5A5A_0000_1234, 1);
      check_eq("co_count", count_o, 3'd1);
      check_eq("co_req", wr_req_o, 1'b1);
      held = wr_data_o;
      check_eq("co_data", held, 128'h5A5A_0000_1234);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sb.delete();
      check_eq("rs_req", wr_req_o, 1'b0);
      check_eq("rs_empty", empty_o, 1'b1);
      check_eq("rs_count", count_o, 3'd0);
      tick();
      check_eq("sb_leftover", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
